// File: rtl/ws2812_pkg.sv
// Shared types and defaults for the multi-channel WS2812 driver.
package ws2812_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StSend,
        StLatch
    } state_e;

    localparam int unsigned DefT0H  = 80;
    localparam int unsigned DefT1H  = 160;
    localparam int unsigned DefTbit = 250;
    localparam int unsigned DefTrst = 60000;

    localparam int unsigned BplGrb  = 3;
    localparam int unsigned BplGrbw = 4;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ws2812_chan_encoder.sv
// One WS2812 line: shifts a byte out MSB first, turning each bit strobe into a timed high pulse.
module ws2812_chan_encoder
    import ws2812_pkg::*;
#(
    parameter int unsigned T0H = DefT0H,
    parameter int unsigned T1H = DefT1H
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       active_in,
    input  logic       enable_in,
    input  logic       bit_stb_in,
    input  logic       load_in,
    input  logic [7:0] byte_in,
    output logic       ws_out
);

    localparam int unsigned HiW = cnt_w(T1H);

    logic [7:0]     shift_q, shift_d;
    logic [HiW-1:0] hi_q, hi_d;
    logic           out_q, out_d;
    logic           cur_bit;

    always_comb begin
        shift_d = shift_q;
        hi_d    = hi_q;
        out_d   = out_q;
        // On a load the new byte's MSB is sent; otherwise the next bit after the current one.
        cur_bit = load_in ? byte_in[7] : shift_q[6];
        if (!active_in) begin
            hi_d  = '0;
            out_d = 1'b0;
        end else if (bit_stb_in) begin
            shift_d = load_in ? byte_in : {shift_q[6:0], 1'b0};
            hi_d    = cur_bit ? HiW'(T1H - 1) : HiW'(T0H - 1);
            out_d   = enable_in;
        end else if (hi_q != '0) begin
            hi_d = hi_q - HiW'(1);
        end else begin
            out_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            shift_q <= '0;
            hi_q    <= '0;
            out_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            hi_q    <= hi_d;
            out_q   <= out_d;
        end
    end

    assign ws_out = out_q;

endmodule

// File: rtl/ws2812_multi_driver.sv
// Double-buffered WS2812 frame driver: NUM_CH lines sent in bit lockstep from per-channel banks.
module ws2812_multi_driver
    import ws2812_pkg::*;
#(
    parameter int unsigned NUM_CH        = 8,
    parameter int unsigned LED_CNT       = 64,
    parameter int unsigned BYTES_PER_LED = BplGrb,
    parameter int unsigned T0H           = DefT0H,
    parameter int unsigned T1H           = DefT1H,
    parameter int unsigned TBIT          = DefTbit,
    parameter int unsigned TRST          = DefTrst,
    localparam int unsigned NBytes       = LED_CNT * BYTES_PER_LED,
    localparam int unsigned ChW          = cnt_w(NUM_CH),
    localparam int unsigned AddrW        = cnt_w(NBytes)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              wr_en_in,
    input  logic [ChW-1:0]    wr_ch_in,
    input  logic [AddrW-1:0]  wr_addr_in,
    input  logic [7:0]        wr_data_in,
    input  logic              start_in,
    input  logic [NUM_CH-1:0] ch_mask_in,
    output logic              busy_out,
    output logic              done_out,
    output logic [NUM_CH-1:0] ws2812_out
);

    if (!(T0H > 0 && T0H < T1H && T1H < TBIT)) begin : g_bad_timing
        $error("ws2812_multi_driver: require 0 < T0H < T1H < TBIT");
    end
    if (BYTES_PER_LED != BplGrb && BYTES_PER_LED != BplGrbw) begin : g_bad_bpl
        $error("ws2812_multi_driver: BYTES_PER_LED must be 3 or 4");
    end
    if (TRST < 1) begin : g_bad_trst
        $error("ws2812_multi_driver: TRST must be at least 1");
    end

    localparam int unsigned TickW = cnt_w(TBIT);
    localparam int unsigned LatW  = cnt_w(TRST);

    state_e            state_q, state_d;
    logic              front_q, front_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [TickW-1:0]  tick_q, tick_d;
    logic [2:0]        bit_q, bit_d;
    logic [AddrW-1:0]  byte_q, byte_d, rd_addr;
    logic [LatW-1:0]   lat_q, lat_d;
    logic              done_q, done_d;
    logic              bit_stb, byte_load, last_bit, send_active, wr_bank;

    logic [7:0] mem [NUM_CH][2][NBytes];
    logic [7:0] rd_byte_q [NUM_CH];

    always_comb begin
        state_d   = state_q;
        front_d   = front_q;
        mask_d    = mask_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        lat_d     = lat_q;
        done_d    = 1'b0;
        bit_stb   = 1'b0;
        byte_load = 1'b0;
        last_bit  = (byte_q == AddrW'(NBytes - 1)) && (bit_q == 3'd7);
        unique case (state_q)
            StIdle: begin
                if (start_in) begin
                    state_d = StLoad;
                    front_d = ~front_q;
                    mask_d  = ch_mask_in;
                end
            end
            StLoad: begin
                bit_stb   = 1'b1;
                byte_load = 1'b1;
                state_d   = StSend;
                tick_d    = '0;
                bit_d     = '0;
                byte_d    = '0;
            end
            StSend: begin
                if (tick_q == TickW'(TBIT - 1)) begin
                    tick_d = '0;
                    if (last_bit) begin
                        state_d = StLatch;
                        lat_d   = '0;
                    end else begin
                        bit_stb = 1'b1;
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            byte_load = 1'b1;
                            byte_d    = byte_q + AddrW'(1);
                        end
                    end
                end else begin
                    tick_d = tick_q + TickW'(1);
                end
            end
            StLatch: begin
                if (lat_q == LatW'(TRST - 1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    lat_d = lat_q + LatW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Prefetch the byte the encoders will load at the next byte boundary from the (new) front bank.
    always_comb begin
        rd_addr = '0;
        if (state_d == StSend && 32'(byte_d) + 32'd1 < NBytes) begin
            rd_addr = byte_d + AddrW'(1);
        end
    end

    assign send_active = (state_d == StSend);
    assign wr_bank     = rst_in ? 1'b1 : ~front_d;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= StIdle;
            front_q <= 1'b0;
            mask_q  <= '0;
            tick_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            lat_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            front_q <= front_d;
            mask_q  <= mask_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            lat_q   <= lat_d;
            done_q  <= done_d;
        end
    end

    // Buffers are never reset; writes follow the post-swap back bank.
    always_ff @(posedge clk_in) begin
        if (wr_en_in && 32'(wr_ch_in) < NUM_CH && 32'(wr_addr_in) < NBytes) begin
            mem[wr_ch_in][wr_bank][wr_addr_in] <= wr_data_in;
        end
    end

    always_ff @(posedge clk_in) begin
        for (int c = 0; c < NUM_CH; c++) begin
            rd_byte_q[c] <= mem[c][front_d][rd_addr];
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ws2812_chan_encoder #(
            .T0H(T0H),
            .T1H(T1H)
        ) u_enc (
            .clk_in    (clk_in),
            .rst_in    (rst_in),
            .active_in (send_active),
            .enable_in (mask_q[c]),
            .bit_stb_in(bit_stb),
            .load_in   (byte_load),
            .byte_in   (rd_byte_q[c]),
            .ws_out    (ws2812_out[c])
        );
    end

    assign busy_out = (state_q != StIdle);
    assign done_out = done_q;

endmodule

// File: tb/tb_ws2812_multi_driver.sv
// Drives a 3-byte and a 4-byte-per-LED driver with identical stimulus and checks both against a frame model.
module tb_ws2812_multi_driver;

    localparam int T0H  = 2;
    localparam int T1H  = 5;
    localparam int TBIT = 8;
    localparam int TRST = 20;
    localparam int MAXW = 1024;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic       wr_ch = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       start = 1'b0;
    logic [1:0] ch_mask = '0;
    logic [1:0] busy, done;
    logic [1:0] ws [2];

    always #5 clk = ~clk;

    ws2812_multi_driver #(
        .NUM_CH(2), .LED_CNT(2), .BYTES_PER_LED(3),
        .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRST(TRST)
    ) dut3 (
        .clk_in(clk), .rst_in(rst), .wr_en_in(wr_en), .wr_ch_in(wr_ch),
        .wr_addr_in(wr_addr), .wr_data_in(wr_data), .start_in(start),
        .ch_mask_in(ch_mask), .busy_out(busy[0]), .done_out(done[0]), .ws2812_out(ws[0])
    );

    ws2812_multi_driver #(
        .NUM_CH(2), .LED_CNT(2), .BYTES_PER_LED(4),
        .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRST(TRST)
    ) dut4 (
        .clk_in(clk), .rst_in(rst), .wr_en_in(wr_en), .wr_ch_in(wr_ch),
        .wr_addr_in(wr_addr), .wr_data_in(wr_data), .start_in(start),
        .ch_mask_in(ch_mask), .busy_out(busy[1]), .done_out(done[1]), .ws2812_out(ws[1])
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Per-frame capture of the lines while busy, plus done pulse count.
    logic       mon_clr = 1'b0;
    logic [1:0] wave [2][MAXW];
    int         wlen [2];
    int         dones [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mon_clr) begin
                wlen[d]  <= 0;
                dones[d] <= 0;
            end else begin
                if (busy[d] === 1'b1 && wlen[d] < MAXW) begin
                    wave[d][wlen[d]] <= ws[d];
                    wlen[d] <= wlen[d] + 1;
                end
                if (done[d] === 1'b1) dones[d] <= dones[d] + 1;
            end
        end
    end

    // Reference model: two banks per channel per DUT, front bank select and frame mask.
    logic [7:0] bank [2][2][2][8];
    logic       front [2];
    logic [1:0] fmask;

    function automatic int nb(input int d);
        return (d == 0) ? 6 : 8;
    endfunction

    function automatic logic exp_lvl(input int d, input int c, input int idx);
        int   k, bitn, t;
        logic v;
        if (idx == 0) return 1'b0;
        k = idx - 1;
        if (k >= nb(d) * 8 * TBIT) return 1'b0;
        bitn = k / TBIT;
        t    = k % TBIT;
        v    = bank[d][c][front[d]][bitn / 8][7 - (bitn % 8)];
        return fmask[c] && (t < (v ? T1H : T0H));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input int c, input int a, input logic [7:0] data);
        for (int d = 0; d < 2; d++) begin
            if (a < nb(d)) bank[d][c][~front[d]][a] = data;
        end
    endtask

    task automatic do_write(input int c, input int a, input logic [7:0] data);
        wr_en = 1'b1; wr_ch = c[0]; wr_addr = a[2:0]; wr_data = data;
        step();
        wr_en = 1'b0;
        model_write(c, a, data);
    endtask

    task automatic fill_back();
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < 8; a++) do_write(c, a, 8'($urandom));
    endtask

    task automatic start_frame(input logic [1:0] mask, input bit cw, input int c, input int a,
                               input logic [7:0] data);
        mon_clr = 1'b1;
        step();
        mon_clr = 1'b0;
        start = 1'b1; ch_mask = mask;
        if (cw) begin
            wr_en = 1'b1; wr_ch = c[0]; wr_addr = a[2:0]; wr_data = data;
        end
        step();
        start = 1'b0; wr_en = 1'b0;
        for (int d = 0; d < 2; d++) front[d] = ~front[d];
        fmask = mask;
        if (cw) model_write(c, a, data);
        check_eq("busy_rise", 32'(busy), 32'h3);
    endtask

    task automatic check_frame(input int d);
        int len, mism;
        len = 1 + nb(d) * 8 * TBIT + TRST;
        check_eq($sformatf("busy_len_d%0d", d), wlen[d], len);
        check_eq($sformatf("done_pulses_d%0d", d), dones[d], 1);
        for (int c = 0; c < 2; c++) begin
            mism = 0;
            for (int i = 0; i < len; i++) begin
                if (i >= wlen[d] || wave[d][i][c] !== exp_lvl(d, c, i)) mism++;
            end
            check_eq($sformatf("wave_d%0d_ch%0d_bad_cycles", d, c), mism, 0);
        end
    endtask

    task automatic wait_frame();
        int n = 0;
        while (busy != 2'b00 && n < 2000) begin
            step();
            n++;
        end
        check_eq("frame_end_within_budget", 32'(n < 2000), 32'd1);
        step();
        step();
        check_frame(0);
        check_frame(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            front[d] = 1'b0;
            for (int c = 0; c < 2; c++)
                for (int b = 0; b < 2; b++)
                    for (int a = 0; a < 8; a++) bank[d][c][b][a] = 8'h00;
        end
        fmask = 2'b00;

        rst = 1'b1;
        step();
        step();
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_done", 32'(done), 32'h0);
        check_eq("rst_ws_d0", 32'(ws[0]), 32'h0);
        check_eq("rst_ws_d1", 32'(ws[1]), 32'h0);
        rst = 1'b0;
        step();

        // Frame 1: ch0 = 0x80 then zeros, ch0 only; refill the back bank while it runs.
        for (int a = 0; a < 8; a++) do_write(0, a, (a == 0) ? 8'h80 : 8'h00);
        for (int a = 0; a < 8; a++) do_write(1, a, 8'($urandom));
        start_frame(2'b01, 1'b0, 0, 0, 8'h00);
        repeat (10) step();
        fill_back();
        do_write(0, 0, 8'hFF);
        wait_frame();

        // Frame 2: ignored restart and an address-6 write mid-SEND.
        start_frame(2'b11, 1'b0, 0, 0, 8'h00);
        repeat (100) step();
        start = 1'b1; ch_mask = 2'b00;
        step();
        start = 1'b0;
        check_eq("busy_after_ignored_start", 32'(busy), 32'h3);
        do_write(0, 6, 8'hA5);
        wait_frame();

        // Frame 3 with a write coincident with start; frame 4 shows where it landed.
        start_frame(2'($urandom_range(1, 3)), 1'b1, 1, 0, 8'($urandom));
        wait_frame();
        start_frame(2'b11, 1'b0, 0, 0, 8'h00);
        wait_frame();

        for (int r = 0; r < 3; r++) begin
            fill_back();
            start_frame(2'($urandom_range(1, 3)), 1'($urandom), $urandom_range(0, 1),
                        $urandom_range(0, 7), 8'($urandom));
            repeat ($urandom_range(5, 300)) step();
            do_write($urandom_range(0, 1), $urandom_range(0, 7), 8'($urandom));
            wait_frame();
        end

        // Reset mid-SEND: lines low at once, no done, front bank back to 0.
        fill_back();
        start_frame(2'b11, 1'b0, 0, 0, 8'h00);
        repeat (60) step();
        rst = 1'b1;
        step();
        check_eq("midrst_ws_d0", 32'(ws[0]), 32'h0);
        check_eq("midrst_ws_d1", 32'(ws[1]), 32'h0);
        check_eq("midrst_busy", 32'(busy), 32'h0);
        check_eq("midrst_done", 32'(done), 32'h0);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) front[d] = 1'b0;
        repeat (30) step();
        check_eq("midrst_no_done_d0", dones[0], 0);
        check_eq("midrst_no_done_d1", dones[1], 0);
        check_eq("midrst_stays_idle", 32'(busy), 32'h0);

        fill_back();
        start_frame(2'b11, 1'b0, 0, 0, 8'h00);
        wait_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
